nway_cache_control: RTL and testbench
=====================================

# nway_cache_control

Controller for a parametrised N-way set-associative, write-back, write-allocate cache. It replaces the fixed 2-way controller and sits between the CPU-side memory port and the cache datapath/RAM port. It owns the per-set tree pseudo-LRU state internally. It prefers invalid ways when choosing a victim and reports one-hot way selects to the datapath.

## Interface
Parameters:
- WAYS, 4, associativity; power of two, at least 2.
- SETS, 16, number of sets; power of two.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- mem_read / mem_write  in  1 each  CPU request; held until mem_resp.
- set_idx  in  $clog2(SETS)  set of the current request; stable while a request is pending.
- hit_way  in  WAYS  one-hot tag-match-and-valid vector from the datapath.
- valid_way, dirty_way  in  WAYS each  status of the indexed set.
- ram_resp_o  in  1  RAM done.
- mem_resp  out  1  one-cycle CPU response.
- way_load  out  WAYS  one-hot array write enable.
- way_idx  out  $clog2(WAYS)  datapath read mux and writeback mux select.
- write_data_sel, write_en_sel, ram_addr_sel  out  enum  datapath muxes.
- valid, dirty  out  1 each  bits written with way_load.
- ram_read_i, ram_write_i  out  1 each  RAM request.

## Operation
- States: IDLE, LOOKUP, WRITEBACK, FETCH, READWRITE.
  - IDLE→LOOKUP on mem_read|mem_write.
  - LOOKUP→IDLE on hit.
  - On miss, LOOKUP→WRITEBACK if dirty_way[victim] & valid_way[victim], else →FETCH.
  - WRITEBACK→FETCH on ram_resp_o.
  - FETCH→READWRITE on ram_resp_o.
  - READWRITE→IDLE.
- Victim, computed in LOOKUP:
  - If any valid_way bit is 0, the victim is the lowest-index invalid way.
  - Otherwise the victim is the PLRU victim.
  - The victim is latched into victim_q on the LOOKUP miss cycle and held through READWRITE.
- PLRU tree, WAYS-1 bits per set:
  - Node i has children 2i+1 and 2i+2.
  - A bit value of 0 means the victim lies in the lower half.
  - On access to way w, each node on w's path is set to point away from w.
  - The tree is updated for set_idx on the LOOKUP-hit cycle (way = hit_way) and on the READWRITE cycle (way = victim_q).
- Outputs by state:
  - LOOKUP hit: mem_resp=1 and way_idx=encode(hit_way). On a write, also way_load=hit_way, CPU_DATA, CPU_EN, valid=1, dirty=1.
  - WRITEBACK: way_idx=victim_q, ram_addr_sel=TAG_ADDR, ram_write_i=1.
  - FETCH: ram_read_i=1, way_load=onehot(victim_q), RAM_DATA, ALL_EN, valid=1, dirty=0.
  - READWRITE: mem_resp=1, way_idx=victim_q. On a write, also way_load=onehot(victim_q), CPU_DATA, CPU_EN, valid=1, dirty=1.
- Illegal inputs:
  - hit_way with more than one bit set is illegal; simulation asserts.
  - mem_read and mem_write both high is treated as a write.
  - A dirty-but-invalid way is treated as clean.

## Timing
- Reset: state=IDLE; every PLRU bit=0. All outputs are 0 and enums are at encoding 0, because outputs decode from state.
- Reset mid-miss: ram_read_i and ram_write_i drop asynchronously; no mem_resp is issued; the request restarts from IDLE.
- Latency, counting the request seen in IDLE as cycle 0:
  - Hit: mem_resp in cycle 1.
  - Clean miss: 3 + (FETCH wait) cycles.
  - Dirty miss: adds the WRITEBACK wait.
  - ram_resp_o on the same cycle the request is raised counts.
- mem_resp is high for exactly one cycle; the next request can be accepted in the following IDLE cycle.
- RAM requests stay asserted continuously until ram_resp_o.

## Configuration
- CACHE_PERF_CNT_EN defined:
  - Adds 32-bit counters perf_req, perf_hit and perf_wb, plus matching output ports.
  - perf_req increments on leaving IDLE; perf_hit on a LOOKUP hit; perf_wb on entering WRITEBACK.
  - Counters reset to 0 and wrap at 2^32.
- Undefined: no counters, no extra ports.

## Structure
- Package cache_types holds write_data_sel_t, write_en_sel_t, ram_addr_sel_t and the state enum nway_cc_state_t.
- Sub-module plru_tree (parameter WAYS) contains combinational victim decode and next-tree computation. The controller owns the SETS×(WAYS-1) storage.

## Test plan
- WAYS=4, cold set, four clean read misses → victims 0,1,2,3 in order. Each goes IDLE-LOOKUP-FETCH-READWRITE with no ram_write_i.
- After filling ways 0..3, hit way 0 → PLRU bits b0=1, b2=0. The next miss selects way 2.
- Write hit on way 1 → way_load=0010, dirty=1, mem_resp in cycle 1. A later miss targeting way 1 → WRITEBACK with way_idx=1, then FETCH.
- Write miss, ram_resp_o delayed 5 cycles in each RAM state → FETCH loads RAM_DATA, then READWRITE loads CPU_DATA with dirty=1. Exactly one mem_resp.
- rst asserted during FETCH → ram_read_i low immediately, PLRU zeroed, state IDLE, no mem_resp.
- With CACHE_PERF_CNT_EN, 10 requests including 6 hits and 2 writebacks → perf_req=10, perf_hit=6, perf_wb=2.

Source files
------------

// File: rtl/nway_cache_control_pkg.sv
// ---------------------------------------------------------------------------
// cache_types: shared types for the N-way cache controller.
//   nway_cc_state_t   - controller FSM state
//   write_data_sel_t  - array write-data source (CPU store data / RAM line)
//   write_en_sel_t    - array byte-enable source (CPU enables / whole line)
//   ram_addr_sel_t    - RAM address source (CPU address / victim tag address)
// Every enum keeps its inactive choice at encoding 0, so an idle controller
// drives all-zero outputs.
// ---------------------------------------------------------------------------
package cache_types;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        WRITEBACK = 3'd2,
        FETCH     = 3'd3,
        READWRITE = 3'd4
    } nway_cc_state_t;

    typedef enum logic {
        CPU_DATA = 1'b0,
        RAM_DATA = 1'b1
    } write_data_sel_t;

    typedef enum logic {
        CPU_EN = 1'b0,
        ALL_EN = 1'b1
    } write_en_sel_t;

    typedef enum logic {
        CPU_ADDR = 1'b0,
        TAG_ADDR = 1'b1
    } ram_addr_sel_t;

    localparam int PERF_W = 32;

endpackage

// File: rtl/nway_cache_control_if.sv
// ---------------------------------------------------------------------------
// nway_cache_control_if: CPU request, datapath status/control and RAM
// handshake signals of the cache controller.
// Handshake semantics: mem_read/mem_write are held by the CPU until the
// single-cycle mem_resp; ram_read_i/ram_write_i are held by the controller
// until the RAM answers with ram_resp_o (a response in the first cycle of a
// request counts).
//   slave  - the controller side
//   master - the CPU / datapath / RAM side
// ---------------------------------------------------------------------------
interface nway_cache_control_if
    import cache_types::*;
#(
    parameter int WAYS = 4,
    parameter int SETS = 16
);
    localparam int IDX_W = $clog2(SETS);
    localparam int WAY_W = $clog2(WAYS);

    logic             mem_read;
    logic             mem_write;
    logic [IDX_W-1:0] set_idx;
    logic [WAYS-1:0]  hit_way;
    logic [WAYS-1:0]  valid_way;
    logic [WAYS-1:0]  dirty_way;
    logic             ram_resp_o;

    logic             mem_resp;
    logic [WAYS-1:0]  way_load;
    logic [WAY_W-1:0] way_idx;
    write_data_sel_t  write_data_sel;
    write_en_sel_t    write_en_sel;
    ram_addr_sel_t    ram_addr_sel;
    logic             valid;
    logic             dirty;
    logic             ram_read_i;
    logic             ram_write_i;

    modport slave (
        input  mem_read, mem_write, set_idx, hit_way, valid_way, dirty_way,
               ram_resp_o,
        output mem_resp, way_load, way_idx, write_data_sel, write_en_sel,
               ram_addr_sel, valid, dirty, ram_read_i, ram_write_i
    );

    modport master (
        output mem_read, mem_write, set_idx, hit_way, valid_way, dirty_way,
               ram_resp_o,
        input  mem_resp, way_load, way_idx, write_data_sel, write_en_sel,
               ram_addr_sel, valid, dirty, ram_read_i, ram_write_i
    );

endinterface

// File: rtl/nway_cache_control_plru.sv
// ---------------------------------------------------------------------------
// plru_tree: combinational tree pseudo-LRU logic for one set.
//   tree       in  WAYS-1      current tree bits (node i -> children 2i+1, 2i+2)
//   access_way in  log2(WAYS)  way being accessed
//   victim     out log2(WAYS)  way the tree currently points at
//   tree_next  out WAYS-1      tree after an access to access_way
// A node bit of 0 points the victim into the lower half of its subtree.
// The victim index bits are exactly the directions taken, MSB first.
// ---------------------------------------------------------------------------
module plru_tree #(
    parameter int WAYS = 4
) (
    input  logic [WAYS-2:0]         tree,
    input  logic [$clog2(WAYS)-1:0] access_way,
    output logic [$clog2(WAYS)-1:0] victim,
    output logic [WAYS-2:0]         tree_next
);
    localparam int LOG = $clog2(WAYS);

    always_comb begin
        logic [LOG-1:0] node;
        logic           dir;
        node   = '0;
        dir    = 1'b0;
        victim = '0;
        for (int l = 0; l < LOG; l++) begin
            dir = tree[node];
            victim[LOG-1-l] = dir;
            // Wraps after the last level; that value is never used.
            node = node + node + LOG'(1) + LOG'(dir);
        end
    end

    always_comb begin
        logic [LOG-1:0] node;
        logic           dir;
        node      = '0;
        dir       = 1'b0;
        tree_next = tree;
        for (int l = 0; l < LOG; l++) begin
            dir = access_way[LOG-1-l];
            tree_next[node] = ~dir;  // point away from the accessed way
            node = node + node + LOG'(1) + LOG'(dir);
        end
    end

endmodule

// File: rtl/nway_cache_control.sv
// ---------------------------------------------------------------------------
// nway_cache_control: controller for an N-way set-associative, write-back,
// write-allocate cache. Owns the per-set tree PLRU state; victims prefer the
// lowest-index invalid way, else the PLRU way.
// Ports:
//   clk, rst  clock; asynchronous active-high reset
//   bus       nway_cache_control_if.slave (CPU request, datapath, RAM)
//   state     current FSM state (debug observation)
//   perf_req, perf_hit, perf_wb  32-bit event counters, present only when
//             CACHE_PERF_CNT_EN is defined
// All outputs decode from the current state, so reset drops RAM requests
// immediately.
// ---------------------------------------------------------------------------
module nway_cache_control
    import cache_types::*;
#(
    parameter int WAYS = 4,
    parameter int SETS = 16
) (
    input  logic                clk,
    input  logic                rst,
    nway_cache_control_if.slave bus,
    output nway_cc_state_t      state
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0]   perf_req,
    output logic [PERF_W-1:0]   perf_hit,
    output logic [PERF_W-1:0]   perf_wb
`endif
);
    localparam int WAY_W = $clog2(WAYS);

    nway_cc_state_t   state_q, state_d;
    logic [WAY_W-1:0] victim_q, victim_c, inv_idx, hit_idx, plru_vic, access_way;
    logic             any_inv, hit, req, is_write, victim_dirty, plru_we;
    logic [WAYS-1:0]  victim_oh;
    logic [WAYS-2:0]  plru_q [SETS];
    logic [WAYS-2:0]  tree_cur, tree_nx;

    assign state    = state_q;
    assign hit      = |bus.hit_way;
    assign req      = bus.mem_read | bus.mem_write;
    assign is_write = bus.mem_write;  // read+write together acts as a write
    assign tree_cur = plru_q[bus.set_idx];

    always_comb begin
        inv_idx = '0;
        any_inv = 1'b0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!bus.valid_way[i]) begin
                inv_idx = WAY_W'(i);
                any_inv = 1'b1;
            end
        end
        hit_idx = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (bus.hit_way[i]) hit_idx = hit_idx | WAY_W'(i);
        end
    end

    assign victim_c     = any_inv ? inv_idx : plru_vic;
    // A dirty bit on an invalid way carries no data worth writing back.
    assign victim_dirty = bus.dirty_way[victim_c] & bus.valid_way[victim_c];
    assign victim_oh    = {{(WAYS-1){1'b0}}, 1'b1} << victim_q;

    assign access_way = (state_q == READWRITE) ? victim_q : hit_idx;
    assign plru_we    = ((state_q == LOOKUP) && hit) || (state_q == READWRITE);

    plru_tree #(.WAYS(WAYS)) u_plru (
        .tree       (tree_cur),
        .access_way (access_way),
        .victim     (plru_vic),
        .tree_next  (tree_nx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            victim_q <= '0;
            for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == LOOKUP) && !hit) victim_q <= victim_c;
            if (plru_we) plru_q[bus.set_idx] <= tree_nx;
        end
    end

    always_comb begin
        state_d            = state_q;
        bus.mem_resp       = 1'b0;
        bus.way_load       = '0;
        bus.way_idx        = '0;
        bus.write_data_sel = CPU_DATA;
        bus.write_en_sel   = CPU_EN;
        bus.ram_addr_sel   = CPU_ADDR;
        bus.valid          = 1'b0;
        bus.dirty          = 1'b0;
        bus.ram_read_i     = 1'b0;
        bus.ram_write_i    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) state_d = LOOKUP;
            end
            LOOKUP: begin
                if (hit) begin
                    bus.mem_resp = 1'b1;
                    bus.way_idx  = hit_idx;
                    if (is_write) begin
                        bus.way_load = bus.hit_way;
                        bus.valid    = 1'b1;
                        bus.dirty    = 1'b1;
                    end
                    state_d = IDLE;
                end else begin
                    state_d = victim_dirty ? WRITEBACK : FETCH;
                end
            end
            WRITEBACK: begin
                bus.way_idx      = victim_q;
                bus.ram_addr_sel = TAG_ADDR;
                bus.ram_write_i  = 1'b1;
                if (bus.ram_resp_o) state_d = FETCH;
            end
            FETCH: begin
                bus.ram_read_i     = 1'b1;
                bus.way_load       = victim_oh;
                bus.write_data_sel = RAM_DATA;
                bus.write_en_sel   = ALL_EN;
                bus.valid          = 1'b1;
                if (bus.ram_resp_o) state_d = READWRITE;
            end
            READWRITE: begin
                bus.mem_resp = 1'b1;
                bus.way_idx  = victim_q;
                if (is_write) begin
                    bus.way_load = victim_oh;
                    bus.valid    = 1'b1;
                    bus.dirty    = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef CACHE_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_req <= '0;
            perf_hit <= '0;
            perf_wb  <= '0;
        end else begin
            if ((state_q == IDLE) && req) perf_req <= perf_req + 1'b1;
            if ((state_q == LOOKUP) && hit) perf_hit <= perf_hit + 1'b1;
            if ((state_q == LOOKUP) && !hit && victim_dirty) perf_wb <= perf_wb + 1'b1;
        end
    end
`endif

    a_hit_onehot: assert property (@(posedge clk) disable iff (rst)
        (state_q == LOOKUP) |-> $onehot0(bus.hit_way));

endmodule

// File: tb/tb_nway_cache_control.sv
module tb_nway_cache_control;
    import cache_types::*;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nway_cache_control_if #(.WAYS(4), .SETS(16)) bus ();
    nway_cc_state_t state;
`ifdef CACHE_PERF_CNT_EN
    logic [31:0] perf_req, perf_hit, perf_wb;
`endif

    nway_cache_control #(.WAYS(4), .SETS(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .state (state)
`ifdef CACHE_PERF_CNT_EN
        ,
        .perf_req (perf_req),
        .perf_hit (perf_hit),
        .perf_wb  (perf_wb)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete CPU request; expected victim/way and path are hand-computed.
    task automatic run_req(input string tag, input bit rd, input bit wr, input int set,
                           input logic [3:0] hit, input logic [3:0] valid_v,
                           input logic [3:0] dirty_v, input int wb_wait,
                           input int fetch_wait, input int exp_vic, input bit exp_wb);
        logic [3:0] vic_oh;
        vic_oh = 4'b0001 << exp_vic;
        bus.mem_read   = rd;
        bus.mem_write  = wr;
        bus.set_idx    = 4'(set);
        bus.hit_way    = hit;
        bus.valid_way  = valid_v;
        bus.dirty_way  = dirty_v;
        bus.ram_resp_o = 1'b0;
        #1;
        check({tag, " idle_state"}, 32'(state), 32'(IDLE));
        check({tag, " idle_resp"}, bus.mem_resp, 0);
        @(posedge clk); #1;
        check({tag, " lookup_state"}, 32'(state), 32'(LOOKUP));
        if (hit != 4'b0000) begin
            check({tag, " hit_resp"}, bus.mem_resp, 1);
            check({tag, " hit_way_idx"}, bus.way_idx, exp_vic);
            check({tag, " hit_way_load"}, bus.way_load, wr ? hit : 4'b0000);
            check({tag, " hit_dirty"}, bus.dirty, wr);
            check({tag, " hit_data_sel"}, bus.write_data_sel, CPU_DATA);
            @(posedge clk); #1;
        end else begin
            check({tag, " miss_resp"}, bus.mem_resp, 0);
            check({tag, " miss_load"}, bus.way_load, 0);
            @(posedge clk); #1;
            if (exp_wb) begin
                for (int c = 0; c <= wb_wait; c++) begin
                    bus.ram_resp_o = (c == wb_wait);
                    #1;
                    check({tag, " wb_state"}, 32'(state), 32'(WRITEBACK));
                    check({tag, " wb_ram_write"}, bus.ram_write_i, 1);
                    check({tag, " wb_way_idx"}, bus.way_idx, exp_vic);
                    check({tag, " wb_addr_sel"}, bus.ram_addr_sel, TAG_ADDR);
                    check({tag, " wb_resp"}, bus.mem_resp, 0);
                    @(posedge clk); #1;
                end
            end
            for (int c = 0; c <= fetch_wait; c++) begin
                bus.ram_resp_o = (c == fetch_wait);
                #1;
                check({tag, " fetch_state"}, 32'(state), 32'(FETCH));
                check({tag, " fetch_ram_read"}, bus.ram_read_i, 1);
                check({tag, " fetch_ram_write"}, bus.ram_write_i, 0);
                check({tag, " fetch_load"}, bus.way_load, vic_oh);
                check({tag, " fetch_data_sel"}, bus.write_data_sel, RAM_DATA);
                check({tag, " fetch_en_sel"}, bus.write_en_sel, ALL_EN);
                check({tag, " fetch_valid"}, bus.valid, 1);
                check({tag, " fetch_dirty"}, bus.dirty, 0);
                check({tag, " fetch_resp"}, bus.mem_resp, 0);
                @(posedge clk); #1;
            end
            bus.ram_resp_o = 1'b0;
            #1;
            check({tag, " rw_state"}, 32'(state), 32'(READWRITE));
            check({tag, " rw_resp"}, bus.mem_resp, 1);
            check({tag, " rw_way_idx"}, bus.way_idx, exp_vic);
            check({tag, " rw_load"}, bus.way_load, wr ? vic_oh : 4'b0000);
            check({tag, " rw_data_sel"}, bus.write_data_sel, CPU_DATA);
            check({tag, " rw_dirty"}, bus.dirty, wr);
            check({tag, " rw_ram_read"}, bus.ram_read_i, 0);
            @(posedge clk); #1;
        end
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        #1;
        check({tag, " end_state"}, 32'(state), 32'(IDLE));
        check({tag, " end_resp"}, bus.mem_resp, 0);
    endtask

    initial begin
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.set_idx    = '0;
        bus.hit_way    = '0;
        bus.valid_way  = '0;
        bus.dirty_way  = '0;
        bus.ram_resp_o = 1'b0;
        #2;
        check("rst_state", 32'(state), 32'(IDLE));
        check("rst_resp", bus.mem_resp, 0);
        check("rst_load", bus.way_load, 0);
        check("rst_ram_read", bus.ram_read_i, 0);
        check("rst_ram_write", bus.ram_write_i, 0);
        check("rst_enums", {bus.write_data_sel, bus.write_en_sel, bus.ram_addr_sel}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // cold set: invalid ways filled lowest-first, no writeback
        run_req("cold0", 1, 0, 3, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0);
        run_req("cold1", 1, 0, 3, 4'b0000, 4'b0001, 4'b0000, 0, 1, 1, 0);
        run_req("cold2", 1, 0, 3, 4'b0000, 4'b0011, 4'b0000, 0, 0, 2, 0);
        run_req("cold3", 1, 0, 3, 4'b0000, 4'b0111, 4'b0000, 0, 2, 3, 0);
        // tree 000; hit way0 -> b0=1,b1=1,b2=0 -> next victim way2
        run_req("hit0", 1, 0, 3, 4'b0001, 4'b1111, 4'b0000, 0, 0, 0, 0);
        run_req("plru_miss2", 1, 0, 3, 4'b0000, 4'b1111, 4'b0000, 0, 0, 2, 0);
        // tree b0=0,b1=1,b2=1; write hit way1 -> b0=1,b1=0
        run_req("wr_hit1", 0, 1, 3, 4'b0010, 4'b1111, 4'b0000, 0, 0, 1, 0);
        // hit way0 then way2 -> b0=0,b1=1,b2=1 -> victim way1 (dirty)
        run_req("hit0b", 1, 0, 3, 4'b0001, 4'b1111, 4'b0010, 0, 0, 0, 0);
        run_req("hit2", 1, 0, 3, 4'b0100, 4'b1111, 4'b0010, 0, 0, 2, 0);
        run_req("dirty_miss1", 1, 0, 3, 4'b0000, 4'b1111, 4'b0010, 2, 1, 1, 1);
        // tree b0=1,b1=0,b2=1 -> victim way3; write miss, 5-cycle waits
        run_req("wr_miss3", 0, 1, 3, 4'b0000, 4'b1111, 4'b1000, 5, 5, 3, 1);
        // leave set 3 pointing at way2 so a lost PLRU reset shows up
        run_req("hit0c", 1, 0, 3, 4'b0001, 4'b1111, 4'b0000, 0, 0, 0, 0);
        // read+write together behaves as a write
        run_req("both_hit2", 1, 1, 5, 4'b0100, 4'b1111, 4'b0000, 0, 0, 2, 0);
        // dirty-but-invalid way0 is clean: straight to FETCH
        run_req("dirty_inv", 1, 0, 7, 4'b0000, 4'b1110, 4'b0001, 0, 0, 0, 0);

        // reset in the middle of a FETCH
        bus.mem_read  = 1'b1;
        bus.set_idx   = 4'd9;
        bus.hit_way   = 4'b0000;
        bus.valid_way = 4'b0000;
        bus.dirty_way = 4'b0000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rstmid_fetch", 32'(state), 32'(FETCH));
        check("rstmid_ram_read_before", bus.ram_read_i, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rstmid_ram_read", bus.ram_read_i, 0);
        check("rstmid_state", 32'(state), 32'(IDLE));
        check("rstmid_resp", bus.mem_resp, 0);
        bus.mem_read = 1'b0;
        @(posedge clk); #1;
        check("rstmid_resp_hold", bus.mem_resp, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rstmid_idle_after", 32'(state), 32'(IDLE));
        check("rstmid_no_resp", bus.mem_resp, 0);

        // ten requests after reset: 6 hits, 2 writebacks
        run_req("r1_plru_zero", 1, 0, 3, 4'b0000, 4'b1111, 4'b0000, 0, 0, 0, 0);
        run_req("r2", 1, 0, 3, 4'b0010, 4'b1111, 4'b0000, 0, 0, 1, 0);
        run_req("r3", 1, 0, 3, 4'b0100, 4'b1111, 4'b0000, 0, 0, 2, 0);
        run_req("r4", 1, 0, 3, 4'b1000, 4'b1111, 4'b0000, 0, 0, 3, 0);
        run_req("r5", 1, 0, 3, 4'b0001, 4'b1111, 4'b0000, 0, 0, 0, 0);
        run_req("r6", 1, 0, 3, 4'b0010, 4'b1111, 4'b0000, 0, 0, 1, 0);
        run_req("r7", 1, 0, 3, 4'b0100, 4'b1111, 4'b0000, 0, 0, 2, 0);
        run_req("r8_wb0", 1, 0, 3, 4'b0000, 4'b1111, 4'b0001, 0, 0, 0, 1);
        run_req("r9_wb3", 0, 1, 3, 4'b0000, 4'b1111, 4'b1000, 1, 0, 3, 1);
        run_req("r10_clean1", 1, 0, 3, 4'b0000, 4'b1111, 4'b1000, 0, 0, 1, 0);
`ifdef CACHE_PERF_CNT_EN
        check("perf_req", perf_req, 10);
        check("perf_hit", perf_hit, 6);
        check("perf_wb", perf_wb, 2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
